keypad_scan_to_hex: RTL

KEYPAD_SCAN_TO_HEX -- requirements
Module: keypad_scan_to_hex

---
 rtl/keypad_scan_to_hex.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_to_hex.sv
// -----------------------------------------------------------------------------
// keypad_scan_to_hex
//
// Scans a 4x4 matrix keypad and turns each debounced press into a hex code.
// One column is driven low at a time. The synchronized row lines are sampled
// once per column slot. A single-row press is debounced and accepted once.
// The column stays frozen until the key has been released and that release
// has been debounced.
//
// Parameters
//   SCAN_DIV    clock cycles per column slot (>= 4, which covers the
//               synchronizer latency after a column change)
//   DEBOUNCE_N  consecutive identical samples needed to accept a press or
//               a release (>= 1)
//
// Ports
//   clock      single clock, rising edge
//   reset      asynchronous, active-high
//   rows[3:0]  keypad rows, active-low, asynchronous to clock
//   cols[3:0]  column drive, active-low one-hot
//   key_code   hex code of the last accepted key
//   key_valid  high while key_code has not been acknowledged
//   key_ack    consumer acknowledge
//   HEX_out    last four accepted codes, newest in [3:0]
//   overrun    sticky flag: a key was accepted over an unconsumed one
//
// Build option
//   KEYPAD_OVERRUN_DETECT_EN  when defined, builds the sticky overrun
//                             detector. Otherwise overrun is tied low.
// -----------------------------------------------------------------------------
module keypad_scan_to_hex #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic [15:0] HEX_out,
    output logic        overrun
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] MATCH_TGT = CW'(DEBOUNCE_N);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    // True when exactly one row line is low.
    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    // Position of the single low row bit.
    function automatic logic [1:0] row_index(input logic [3:0] v);
        case (v)
            4'b1110: row_index = 2'd0;
            4'b1101: row_index = 2'd1;
            4'b1011: row_index = 2'd2;
            default: row_index = 2'd3;
        endcase
    endfunction

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] i);
        col_drive = ~(4'b0001 << i);
    endfunction

    state_t          state_r;
    logic [3:0]      sync1_r;
    logic [3:0]      sync2_r;
    logic [SW-1:0]   slot_r;
    logic [1:0]      idx_r;
    logic [3:0]      cols_r;
    logic [CW-1:0]   match_r;
    logic [3:0]      pattern_r;
    logic [3:0]      key_code_r;
    logic            key_valid_r;
    logic [15:0]     hex_r;
    logic            sample_s;
    logic            accept_s;
    logic [3:0]      accept_code_s;

    assign sample_s      = (slot_r == SLOT_LAST);
    // In DEBOUNCE the sample equals the latched pattern whenever we accept,
    // so the live sample is a valid source for the row index in both paths.
    assign accept_code_s = {row_index(sync2_r), idx_r};

    // Acceptance decision for the current cycle.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if (sample_s && one_low(sync2_r) && (MATCH_TGT == CW'(1))) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_DEBOUNCE: begin
                if (sample_s && (sync2_r == pattern_r) &&
                    ((match_r + CW'(1)) == MATCH_TGT)) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: accept_s = 1'b0;
        endcase
    end

    // Synchronizer, slot timer, column index and scan/debounce/release FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_SCAN;
            sync1_r   <= 4'b1111;
            sync2_r   <= 4'b1111;
            slot_r    <= '0;
            idx_r     <= 2'd0;
            cols_r    <= 4'b1110;
            match_r   <= '0;
            pattern_r <= 4'b1111;
        end else begin
            sync1_r <= rows;
            sync2_r <= sync1_r;
            slot_r  <= sample_s ? '0 : slot_r + SW'(1);
            if (sample_s) begin
                case (state_r)
                    ST_SCAN: begin
                        if (one_low(sync2_r)) begin
                            pattern_r <= sync2_r;
                            if (accept_s) begin
                                state_r <= ST_RELEASE;
                                match_r <= '0;
                            end else begin
                                state_r <= ST_DEBOUNCE;
                                match_r <= CW'(1);
                            end
                        end else begin
                            idx_r  <= idx_r + 2'd1;
                            cols_r <= col_drive(idx_r + 2'd1);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (sync2_r == pattern_r) begin
                            if (accept_s) begin
                                state_r <= ST_RELEASE;
                                match_r <= '0;
                            end else begin
                                match_r <= match_r + CW'(1);
                            end
                        end else begin
                            state_r <= ST_SCAN;
                            match_r <= '0;
                            idx_r   <= idx_r + 2'd1;
                            cols_r  <= col_drive(idx_r + 2'd1);
                        end
                    end
                    ST_RELEASE: begin
                        // match_r counts consecutive all-high samples here.
                        if (sync2_r == 4'b1111) begin
                            if ((match_r + CW'(1)) == MATCH_TGT) begin
                                state_r <= ST_SCAN;
                                match_r <= '0;
                                idx_r   <= idx_r + 2'd1;
                                cols_r  <= col_drive(idx_r + 2'd1);
                            end else begin
                                match_r <= match_r + CW'(1);
                            end
                        end else begin
                            match_r <= '0;
                        end
                    end
                    default: begin
                        state_r <= ST_SCAN;
                        match_r <= '0;
                    end
                endcase
            end
        end
    end

    // Key code, history shift register and valid/ack handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            hex_r       <= 16'h0000;
        end else if (accept_s) begin
            // A new key wins over a same-cycle ack: valid stays high.
            key_code_r  <= accept_code_s;
            key_valid_r <= 1'b1;
            hex_r       <= {hex_r[11:0], accept_code_s};
        end else if (key_ack) begin
            key_valid_r <= 1'b0;
        end
    end

`ifdef KEYPAD_OVERRUN_DETECT_EN
    logic overrun_r;

    // Sticky overrun: acceptance over an unconsumed, unacknowledged key.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (accept_s && key_valid_r && !key_ack) begin
            overrun_r <= 1'b1;
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

    assign cols      = cols_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign HEX_out   = hex_r;

endmodule
